// File: rtl/pipe_addsub_pkg.sv
// pipe_addsub shared definitions: mode encoding and chunk sizing.
// Imported by the pipelined adder/subtractor top.
package pipe_addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_addsub_stage.sv
// One carry-chunk stage of pipe_addsub: adds chunk IDX and registers
// carry, valid, skewed operands and deskewed partial sum.
module pipe_addsub_stage #(
  parameter int WIDTH = 32,
  parameter int CW    = 8,
  parameter int IDX   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_carry,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  output logic             out_valid,
  output logic             out_carry,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum
);

  localparam int LO = IDX * CW;

  logic [CW:0]      part;
  logic [WIDTH-1:0] sum_next;

  assign part = {1'b0, in_a[LO +: CW]}
              + {1'b0, in_b[LO +: CW]}
              + {{CW{1'b0}}, in_carry};

  always_comb begin
    sum_next           = in_sum;
    sum_next[LO +: CW] = part[CW-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_carry <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sum   <= '0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (advance)
        out_valid <= in_valid;
      if (advance) begin
        out_carry <= part[CW];
        out_a     <= in_a;
        out_b     <= in_b;
        out_sum   <= sum_next;
      end
    end
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined chunked adder/subtractor, STAGES carry chunks, valid/ready.
// Define PIPE_ADDSUB_OVF_EN to add the signed overflow output.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef PIPE_ADDSUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  logic             advance;
  logic             v_p [STAGES+1];
  logic             c_p [STAGES+1];
  logic [WIDTH-1:0] a_p [STAGES+1];
  logic [WIDTH-1:0] b_p [STAGES+1];
  logic [WIDTH-1:0] s_p [STAGES+1];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !flush;

  // subtract is a + ~b + 1, so the mode supplies the carry in
  assign v_p[0] = in_valid && in_ready;
  assign c_p[0] = (sub == SUB) ? 1'b1 : carry_in;
  assign a_p[0] = a;
  assign b_p[0] = (sub == SUB) ? ~b : b;
  assign s_p[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_addsub_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .IDX   (k)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .advance   (advance),
      .flush     (flush),
      .in_valid  (v_p[k]),
      .in_carry  (c_p[k]),
      .in_a      (a_p[k]),
      .in_b      (b_p[k]),
      .in_sum    (s_p[k]),
      .out_valid (v_p[k+1]),
      .out_carry (c_p[k+1]),
      .out_a     (a_p[k+1]),
      .out_b     (b_p[k+1]),
      .out_sum   (s_p[k+1])
    );
  end

  assign out_valid = v_p[STAGES];
  assign sum       = s_p[STAGES];
  assign carry_out = c_p[STAGES];

`ifdef PIPE_ADDSUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic s_msb;

  assign a_msb    = a_p[STAGES][WIDTH-1];
  assign b_msb    = b_p[STAGES][WIDTH-1];
  assign s_msb    = s_p[STAGES][WIDTH-1];
  assign overflow = (a_msb == b_msb) && (s_msb != a_msb);
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: queue-based reference model,
// directed corner cases, stall/flush/reset scenarios and random traffic.
module tb_pipe_addsub;
  import pipe_addsub_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct packed {
    logic             ovf;
    logic             cout;
    logic [WIDTH-1:0] s;
  } res_t;

  logic             clock     = 1'b0;
  logic             reset     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             carry_in  = 1'b0;
  logic             sub       = 1'b0;
  logic             flush     = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef PIPE_ADDSUB_OVF_EN
  logic             overflow;
`endif

  res_t q[$];
  int   n_vec     = 0;
  int   n_err     = 0;
  int   n_pop     = 0;
  bit   saw_stall = 1'b0;
  bit   rand_on   = 1'b0;

  pipe_addsub #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef PIPE_ADDSUB_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clock = ~clock;

  // Plain integer arithmetic reference for one beat
  function automatic res_t model(input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y,
                                 input logic ci,
                                 input logic md);
    res_t           r;
    longint         sx, sy, sr, smax, smin;
    logic [WIDTH:0] w;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    if (md == SUB) begin
      r.s    = x - y;
      r.cout = (x >= y);
      sr     = sx - sy;
    end else begin
      w      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
      r.s    = w[WIDTH-1:0];
      r.cout = w[WIDTH];
      sr     = sx + sy + longint'(ci);
    end
    r.ovf = (sr > smax) || (sr < smin);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      q.delete();
    end else begin
      chk("in_ready", in_ready, (!out_valid || out_ready) && !flush);
      if (in_valid && !in_ready && !flush)
        saw_stall = 1'b1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious out_valid", out_valid, 0);
        end else begin
          chk("sum", sum, q[0].s);
          chk("carry_out", carry_out, q[0].cout);
`ifdef PIPE_ADDSUB_OVF_EN
          chk("overflow", overflow, q[0].ovf);
`endif
          if (out_ready) begin
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(a, b, carry_in, sub));
      if (flush)
        q.delete();
    end
  end

  task automatic drive(input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y,
                       input logic ci,
                       input logic md);
    bit ok;
    ok       = 1'b0;
    a        = x;
    b        = y;
    carry_in = ci;
    sub      = md;
    in_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok)
      chk("accept timeout", in_ready, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Called right after an acceptance edge; counts cycles to out_valid
  task automatic lat_check(input string nm);
    int k;
    for (k = 1; k <= STAGES + 4; k++) begin
      @(negedge clock);
      if (out_valid)
        break;
    end
    chk(nm, k, STAGES);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return {1'b0, {(WIDTH-1){1'b1}}};
      default: return WIDTH'($urandom());
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pop0;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset sum", sum, 0);
    chk("reset carry_out", carry_out, 0);

    chk("model add", model(32'hA5A5A5A5, 32'h5A5A5A5A, 0, ADD),
        {2'b00, 32'hFFFFFFFF});
    chk("model wrap", model(32'hFFFFFFFF, 32'h1, 0, ADD),
        {2'b01, 32'h0});
    chk("model sub borrow", model(32'h5, 32'h7, 0, SUB),
        {2'b00, 32'hFFFFFFFE});
    chk("model sub", model(32'h7, 32'h5, 1, SUB),
        {2'b01, 32'h2});
    chk("model ovf add", model(32'h7FFFFFFF, 32'h1, 0, ADD),
        {2'b10, 32'h80000000});
    chk("model ovf sub", model(32'h80000000, 32'h1, 0, SUB),
        {2'b11, 32'h7FFFFFFF});

    idle(2);
    reset = 1'b0;
    idle(1);

    drive(32'hA5A5A5A5, 32'h5A5A5A5A, 0, ADD);
    lat_check("latency first");
    idle(2);
    drive(32'hFFFFFFFF, 32'h00000001, 0, ADD);
    drive(32'h00000005, 32'h00000007, 0, SUB);
    drive(32'h00000007, 32'h00000005, 1, SUB);
    drive(32'h7FFFFFFF, 32'h00000001, 0, ADD);
    drive(32'h80000000, 32'h00000001, 0, SUB);
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1, ADD);
    idle(8);
    chk("directed drained", q.size(), 0);

    pop0 = n_pop;
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive(WIDTH'($urandom()), WIDTH'($urandom()),
                1'($urandom()), 1'($urandom()));
      end
      begin
        repeat (5) @(posedge clock);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(10);
    chk("stall in_ready drop", saw_stall, 1);
    chk("stall delivered", n_pop - pop0, 6);
    chk("stall drained", q.size(), 0);

    drive(32'h11111111, 32'h22222222, 0, ADD);
    drive(32'h33333333, 32'h44444444, 1, ADD);
    drive(32'h55555555, 32'h66666666, 0, SUB);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset sum", sum, 0);
    chk("async reset carry_out", carry_out, 0);
`ifdef PIPE_ADDSUB_OVF_EN
    chk("async reset overflow", overflow, 0);
`endif
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("post reset quiet", out_valid, 0);
    end
    @(posedge clock);
    #1;
    drive(32'h0000FFFF, 32'h00000001, 0, ADD);
    lat_check("latency after reset");
    idle(6);

    drive(32'h12345678, 32'h87654321, 0, ADD);
    drive(32'hDEADBEEF, 32'h00000001, 0, SUB);
    flush    = 1'b1;
    in_valid = 1'b1;
    a        = 32'hCAFEF00D;
    b        = 32'h1;
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("post flush quiet", out_valid, 0);
    end
    @(posedge clock);
    #1;
    drive(32'h00FF00FF, 32'h0F0F0F0F, 0, ADD);
    lat_check("latency after flush");
    idle(6);

    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clock);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          drive(pick(), pick(), 1'($urandom()), 1'($urandom()));
          if ($urandom_range(0, 3) == 0)
            idle(1);
        end
        rand_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++)
      @(posedge clock);
    #1;
    chk("random drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
